quant_sequencer: RTL and testbench

//  Sequences the 8x8 quantizer datapath: accepts DCT columns (8 x 10-bit signed) with valid/ready,

---
 rtl/quant_sequencer_pkg.sv | 22 ++
 rtl/quant_sequencer_if.sv | 31 +++
 rtl/quant_sequencer.sv | 136 +++++++++++++
 tb/tb_quant_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quant_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : quant_sequencer_pkg
// Description : Shared constants and state type for the quantizer sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package quant_sequencer_pkg;

    localparam int N     = 8;
    localparam int IN_W  = 10;
    localparam int OUT_W = 8;

    localparam logic [2:0] c_last_col = 3'd7;
    localparam logic [7:0] c_drop_max = 8'hFF;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/quant_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : quant_sequencer_if
// Description : Column input and quantized-column output handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
interface quant_sequencer_if;
    import quant_sequencer_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_sob;
    logic [N*IN_W-1:0]     in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [N*OUT_W-1:0]    out_data;
    logic [2:0]            out_col;
    logic                  out_eob;

    modport slave (
        input  in_valid, in_sob, in_data, out_ready,
        output in_ready, out_valid, out_data, out_col, out_eob
    );

    modport master (
        output in_valid, in_sob, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_col, out_eob
    );

endinterface
`default_nettype wire

// File: rtl/quant_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : quant_sequencer
// Description : Aligns DCT columns into 8x8 blocks, drives the external
//               quantizer and registers its result into a one-deep output.
// Revision    : 1.0 - initial release
// ============================================================================
module quant_sequencer
    import quant_sequencer_pkg::*;
#(
    parameter int BLK_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    quant_sequencer_if.slave     bus,
    output logic [N*IN_W-1:0]    q_in,
    output logic [2:0]           q_count,
    input  logic [N*OUT_W-1:0]   q_out,
    output logic                 sync_err,
    output logic [7:0]           drop_cnt,
    output logic [BLK_W-1:0]     blk_cnt
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [2:0]           r_col;
    logic [2:0]           w_col_nxt;
    logic [2:0]           w_index;
    logic                 w_in_fire;
    logic                 w_capture;
    logic                 w_drop;
    logic                 w_sync;
    logic                 w_eob;

    logic                 r_out_valid;
    logic [N*OUT_W-1:0]   r_out_data;
    logic [2:0]           r_out_col;
    logic                 r_out_eob;
    logic                 r_sync_err;
    logic [7:0]           r_drop_cnt;
    logic [BLK_W-1:0]     r_blk_cnt;

    assign bus.in_ready = !r_out_valid || bus.out_ready;
    assign w_in_fire    = bus.in_valid && bus.in_ready;
    // A start-of-block beat always restarts at column 0, even mid-block.
    assign w_index      = bus.in_sob ? 3'd0 : r_col;
    assign w_eob        = w_capture && (w_index == c_last_col);

    assign q_in    = bus.in_data;
    assign q_count = w_index;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_col   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_capture   = 1'b0;
        w_drop      = 1'b0;
        w_sync      = 1'b0;
        if (w_in_fire) begin
            case (r_state)
                IDLE: begin
                    if (bus.in_sob) begin
                        w_capture   = 1'b1;
                        w_col_nxt   = 3'd1;
                        w_state_nxt = ACTIVE;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
                ACTIVE: begin
                    w_capture = 1'b1;
                    if (bus.in_sob) begin
                        w_sync    = (r_col != 3'd0);
                        w_col_nxt = 3'd1;
                    end else if (r_col == c_last_col) begin
                        w_col_nxt   = 3'd0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_col_nxt = r_col + 3'd1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_col_nxt   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_col   <= 3'd0;
            r_out_eob   <= 1'b0;
            r_sync_err  <= 1'b0;
            r_drop_cnt  <= 8'd0;
            r_blk_cnt   <= '0;
        end else begin
            r_sync_err <= w_sync;
            if (w_capture) begin
                r_out_valid <= 1'b1;
                r_out_data  <= q_out;
                r_out_col   <= w_index;
                r_out_eob   <= w_eob;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_drop && (r_drop_cnt != c_drop_max)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
            if (w_eob) begin
                r_blk_cnt <= r_blk_cnt + {{(BLK_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_col   = r_out_col;
    assign bus.out_eob   = r_out_eob;
    assign sync_err      = r_sync_err;
    assign drop_cnt      = r_drop_cnt;
    assign blk_cnt       = r_blk_cnt;

endmodule
`default_nettype wire

// File: tb/tb_quant_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_quant_sequencer
// Description : Randomized self-checking bench with a block-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quant_sequencer;
    import quant_sequencer_pkg::*;

    localparam int BLK_W = 4;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  col;
        logic        eob;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [79:0]      q_in;
    logic [2:0]       q_count;
    logic [63:0]      q_out;
    logic             sync_err;
    logic [7:0]       drop_cnt;
    logic [BLK_W-1:0] blk_cnt;

    int    vectors = 0;
    int    errors  = 0;
    beat_t exp_q[$];
    int    m_col  = 0;
    bit    m_open = 0;
    int    m_drop = 0;
    int    m_blk  = 0;
    bit    m_sync = 0;
    bit    rand_ready = 0;

    always #5 clk = ~clk;

    quant_sequencer_if bus();

    quant_sequencer #(.BLK_W(BLK_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .q_in     (q_in),
        .q_count  (q_count),
        .q_out    (q_out),
        .sync_err (sync_err),
        .drop_cnt (drop_cnt),
        .blk_cnt  (blk_cnt)
    );

    // Stand-in quantizer: divide by a column/row dependent step, round half away from zero, saturate.
    function automatic logic [63:0] quantize(input logic [79:0] col, input int cnt);
        logic [63:0] r;
        int c, s, q;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            c = int'($signed(col[79-10*i -: 10]));
            s = 2 + i + cnt;
            if (c >= 0) q = (c + s/2) / s;
            else        q = -((-c + s/2) / s);
            if (q > 127)  q = 127;
            if (q < -128) q = -128;
            r[63-8*i -: 8] = q[7:0];
        end
        return r;
    endfunction

    assign q_out = quantize(q_in, int'(q_count));

    function automatic logic [79:0] rand_col();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[79:0];
    endfunction

    task automatic tick(output bit fired);
        beat_t       b;
        int          idx;
        bit          mready, in_fire, out_fire, s_sob;
        logic [79:0] s_data;
        @(negedge clk);
        fired = 0;
        vectors++;
        if (bus.out_valid !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL out_valid: got %b want %0b", bus.out_valid, exp_q.size() != 0);
        end
        mready = (exp_q.size() == 0) || bus.out_ready;
        vectors++;
        if (bus.in_ready !== mready) begin
            errors++;
            $display("FAIL in_ready: got %b want %0b", bus.in_ready, mready);
        end
        if (exp_q.size() != 0 && bus.out_valid === 1'b1) begin
            b = exp_q[0];
            vectors++;
            if (bus.out_data !== b.data || bus.out_col !== b.col || bus.out_eob !== b.eob) begin
                errors++;
                $display("FAIL out_beat: got data=%h col=%0d eob=%b want data=%h col=%0d eob=%b",
                         bus.out_data, bus.out_col, bus.out_eob, b.data, b.col, b.eob);
            end
        end
        s_sob  = bus.in_sob;
        s_data = bus.in_data;
        idx    = s_sob ? 0 : m_col;
        if (bus.in_valid) begin
            vectors++;
            if (q_count !== idx[2:0] || q_in !== s_data) begin
                errors++;
                $display("FAIL quant_drive: got count=%0d in=%h want count=%0d in=%h",
                         q_count, q_in, idx, s_data);
            end
        end
        in_fire  = bus.in_valid && mready;
        out_fire = (exp_q.size() != 0) && bus.out_ready;
        @(posedge clk);
        if (!reset) begin
            exp_q.delete();
            m_col = 0; m_open = 0; m_drop = 0; m_blk = 0; m_sync = 0;
        end else begin
            m_sync = 0;
            if (out_fire) void'(exp_q.pop_front());
            if (in_fire) begin
                fired = 1;
                if (!m_open && !s_sob) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    if (m_open && s_sob) m_sync = 1;
                    b.data = quantize(s_data, idx);
                    b.col  = idx[2:0];
                    b.eob  = (idx == 7);
                    exp_q.push_back(b);
                    if (idx == 7) begin
                        m_blk  = (m_blk + 1) % (1 << BLK_W);
                        m_open = 0;
                        m_col  = 0;
                    end else begin
                        m_open = 1;
                        m_col  = idx + 1;
                    end
                end
            end
        end
        #1;
        vectors++;
        if (sync_err !== m_sync || drop_cnt !== m_drop[7:0] || blk_cnt !== m_blk[BLK_W-1:0]) begin
            errors++;
            $display("FAIL counters: got sync=%b drop=%0d blk=%0d want sync=%0b drop=%0d blk=%0d",
                     sync_err, drop_cnt, blk_cnt, m_sync, m_drop, m_blk);
        end
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_beat(input bit sob, input logic [79:0] d);
        bit f;
        int n;
        bus.in_valid = 1'b1;
        bus.in_sob   = sob;
        bus.in_data  = d;
        f = 0;
        n = 0;
        while (!f && n < 50) begin
            tick(f);
            n++;
        end
        if (!f) begin
            errors++;
            $display("FAIL accept_timeout: got no accept in %0d cycles want accept", n);
        end
    endtask

    task automatic idle(input int cycles);
        bit f;
        bus.in_valid = 1'b0;
        bus.in_sob   = 1'b0;
        for (int i = 0; i < cycles; i++) tick(f);
    endtask

    task automatic send_block();
        for (int c = 0; c < 8; c++) send_beat(c == 0, rand_col());
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 64'd0 || bus.out_col !== 3'd0 ||
            bus.out_eob !== 1'b0 || sync_err !== 1'b0 || drop_cnt !== 8'd0 || blk_cnt !== '0) begin
            errors++;
            $display("FAIL reset_values: got v=%b d=%h c=%0d e=%b s=%b dr=%0d b=%0d want all zero",
                     bus.out_valid, bus.out_data, bus.out_col, bus.out_eob, sync_err, drop_cnt, blk_cnt);
        end
        reset = 1'b1;
        idle(2);
    endtask

    task automatic test_single_block();
        bus.out_ready = 1'b1;
        send_block();
        idle(3);
        vectors++;
        if (blk_cnt !== 4'd1) begin
            errors++;
            $display("FAIL single_block_cnt: got %0d want 1", blk_cnt);
        end
    endtask

    task automatic test_backpressure();
        bit          f;
        logic [63:0] held;
        logic [79:0] d3;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) send_beat(c == 0, rand_col());
        bus.out_ready = 1'b0;
        d3 = rand_col();
        bus.in_valid = 1'b1;
        bus.in_sob   = 1'b0;
        bus.in_data  = d3;
        held = bus.out_data;
        for (int i = 0; i < 3; i++) begin
            tick(f);
            vectors++;
            if (f || bus.out_data !== held || bus.out_col !== 3'd2) begin
                errors++;
                $display("FAIL backpressure_hold: got fired=%0b col=%0d data=%h want fired=0 col=2 data=%h",
                         f, bus.out_col, bus.out_data, held);
            end
        end
        bus.out_ready = 1'b1;
        send_beat(1'b0, d3);
        for (int c = 4; c < 8; c++) send_beat(1'b0, rand_col());
        idle(3);
    endtask

    task automatic test_drop();
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_beat(1'b0, rand_col());
        idle(1);
        vectors++;
        if (drop_cnt !== 8'd3 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_count: got drop=%0d valid=%b want drop=3 valid=0", drop_cnt, bus.out_valid);
        end
        send_block();
        for (int i = 0; i < 260; i++) send_beat(1'b0, rand_col());
        idle(1);
        vectors++;
        if (drop_cnt !== 8'd255) begin
            errors++;
            $display("FAIL drop_saturate: got %0d want 255", drop_cnt);
        end
    endtask

    task automatic test_sync();
        int blk0;
        blk0 = m_blk;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) send_beat(c == 0, rand_col());
        send_beat(1'b1, rand_col());
        vectors++;
        if (sync_err !== 1'b1 || blk_cnt !== blk0[BLK_W-1:0]) begin
            errors++;
            $display("FAIL sync_pulse: got sync=%b blk=%0d want sync=1 blk=%0d", sync_err, blk_cnt, blk0);
        end
        for (int c = 1; c < 8; c++) send_beat(1'b0, rand_col());
        idle(2);
        vectors++;
        if (sync_err !== 1'b0 || blk_cnt !== 4'((blk0 + 1) % 16)) begin
            errors++;
            $display("FAIL sync_realign: got sync=%b blk=%0d want sync=0 blk=%0d",
                     sync_err, blk_cnt, (blk0 + 1) % 16);
        end
    endtask

    task automatic test_reset_mid_block();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) send_beat(c == 0, rand_col());
        bus.out_ready = 1'b0;
        idle(1);
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        vectors++;
        if (bus.out_valid !== 1'b0 || drop_cnt !== 8'd0 || blk_cnt !== '0) begin
            errors++;
            $display("FAIL reset_mid_block: got valid=%b drop=%0d blk=%0d want 0 0 0",
                     bus.out_valid, drop_cnt, blk_cnt);
        end
        bus.out_ready = 1'b1;
        send_beat(1'b0, rand_col());
        idle(1);
        vectors++;
        if (drop_cnt !== 8'd1) begin
            errors++;
            $display("FAIL reset_idle_state: got drop=%0d want 1", drop_cnt);
        end
    endtask

    task automatic test_back_to_back();
        reset = 1'b0;
        idle(1);
        reset = 1'b1;
        rand_ready = 1;
        for (int blk = 0; blk < (1 << BLK_W) + 1; blk++) begin
            for (int c = 0; c < 8; c++) begin
                if ($urandom_range(0, 7) == 0) idle(1);
                send_beat(c == 0, rand_col());
            end
        end
        rand_ready = 0;
        bus.out_ready = 1'b1;
        idle(3);
        vectors++;
        if (blk_cnt !== 4'd1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL blk_wrap: got blk=%0d pending=%0d want blk=1 pending=0", blk_cnt, exp_q.size());
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sob    = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_single_block();
        test_backpressure();
        test_drop();
        test_sync();
        test_reset_mid_block();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
